nco_sweep_ctrl: RTL and testbench
=================================

NCO_SWEEP_CTRL -- requirements
Module: nco_sweep_ctrl

Interface
REQ-001 The block SHALL have parameter PHI_W, default 8, meaning the width of the NCO phase increment.
REQ-002 The block SHALL have parameter DWELL_W, default 16, meaning the width of the dwell counter.
REQ-003 The block SHALL have port sys_clk, input, 1 bit: the single clock for all logic.
REQ-004 The block SHALL have port sys_rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port start, input, 1 bit: a one-cycle sweep start request.
REQ-006 The block SHALL have port stop, input, 1 bit: abort the sweep in progress.
REQ-007 The block SHALL have port cfg_start_inc, input, PHI_W bits: the first phase increment of the sweep.
REQ-008 The block SHALL have port cfg_stop_inc, input, PHI_W bits: the last phase increment of the sweep.
REQ-009 The block SHALL have port cfg_step, input, PHI_W bits: the increment change per step.
REQ-010 The block SHALL have port cfg_dwell, input, DWELL_W bits: the hold time per value, minus 1, in cycles.
REQ-011 The block SHALL have port cfg_repeat, input, 1 bit: 1 = restart the sweep from cfg_start_inc after reaching cfg_stop_inc.
REQ-012 The block SHALL have port phi_inc, output, PHI_W bits: registered phase increment driven to the NCO.
REQ-013 The block SHALL have port nco_clken, output, 1 bit: registered NCO clock enable.
REQ-014 The block SHALL have port busy, output, 1 bit: asserted while a sweep is active.
REQ-015 The block SHALL have port done, output, 1 bit: one-cycle pulse on normal sweep completion.
REQ-016 The block SHALL have port wrap, output, 1 bit: one-cycle pulse when a repeat sweep restarts.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, DWELL and DONE, and all outputs SHALL be registered.
REQ-018 In IDLE, start=1 and stop=0 SHALL cause the following on the next edge:
- latch all cfg_* inputs; they are ignored after this edge until the next start;
- set phi_inc=cfg_start_inc, nco_clken=1, busy=1;
- clear the dwell counter to 0;
- enter DWELL.
REQ-019 Sweep direction SHALL be fixed at latch time: up if latched start_inc <= stop_inc, otherwise down.
REQ-020 A latched step of 0 SHALL be treated as 1, so that every sweep terminates.
REQ-021 In DWELL, each phi_inc value SHALL be held for exactly dwell+1 cycles; dwell=0 gives 1 cycle per value.
REQ-022 On dwell expiry with phi_inc != stop_inc:
- phi_inc SHALL advance by step;
- the sum or difference SHALL be computed at PHI_W+1 bits and clamped to stop_inc, so that it never overshoots, overflows or underflows;
- the counter SHALL be cleared.
REQ-023 On dwell expiry with phi_inc == stop_inc and repeat=1, phi_inc SHALL reload start_inc and wrap SHALL pulse for 1 cycle, coincident with the reload.
REQ-024 On dwell expiry with phi_inc == stop_inc and repeat=0, the FSM SHALL enter DONE with the following values in that cycle:
- done=1, busy=0, nco_clken=0;
- phi_inc holds its last value.
REQ-025 DONE SHALL last exactly one cycle and then return to IDLE with done=0.
REQ-026 stop=1 in DWELL SHALL, on the next edge, return the FSM to IDLE with busy=0, nco_clken=0 and done=0, with phi_inc holding its value.
REQ-027 stop in IDLE or DONE SHALL have no effect.
REQ-028 start while busy=1 or in DONE SHALL be ignored.
REQ-029 If start and stop are both 1 in IDLE, stop SHALL win and the FSM SHALL stay in IDLE.
REQ-030 If stop and dwell expiry coincide, stop SHALL win: no done and no wrap.
REQ-031 start_inc == stop_inc SHALL give a single value held for dwell+1 cycles, then DONE (or a wrap each period if repeat=1).

Reset
REQ-032 sys_rst=1 SHALL, at the next edge, force the following regardless of state:
- state=IDLE;
- phi_inc=0, nco_clken=0, busy=0, done=0, wrap=0;
- dwell counter=0;
- latched configuration=0.
REQ-033 Reset asserted mid-sweep SHALL abandon the sweep without pulsing done or wrap.
REQ-034 Reset SHALL have priority over start and stop.

Verification
REQ-035 A bench SHALL cover the nominal up sweep: start=10, stop=40, step=10, dwell=2, repeat=0, start pulse at cycle 0 -> phi_inc 10/20/30/40, each held for 3 cycles (cycles 1-12), then done=1 and busy=0 at cycle 13.
REQ-036 A bench SHALL cover clamping: start=250, stop=255, step=10, dwell=0 -> phi_inc 250, then 255 (no wrap to 4), then done.
REQ-037 A bench SHALL cover the down sweep with repeat: start=200, stop=190, step=5, dwell=0, repeat=1 -> phi_inc 200, 195, 190, then 200 with wrap=1 for that cycle, continuing until stop.
REQ-038 A bench SHALL cover abort: stop asserted in the 2nd dwell cycle of value 20 (setup from REQ-035) -> next cycle busy=0, nco_clken=0, phi_inc=20, done never asserted; a start+stop pulse in IDLE -> busy remains 0.
REQ-039 A bench SHALL cover zero step and single value: start=50, stop=50, step=0, dwell=3 -> phi_inc=50 for 4 cycles, then done; a start issued during those cycles is ignored.
REQ-040 A bench SHALL cover reset mid-sweep: sys_rst asserted in DWELL -> next cycle all outputs 0 and no done pulse; a fresh start afterwards runs normally.

Source files
------------

// File: rtl/nco_sweep_ctrl.sv
// NCO frequency sweep controller.
// Steps a registered phase increment from a start value to a stop value
// (up or down), holding each value for dwell+1 cycles, with optional repeat.
module nco_sweep_ctrl #(
  parameter int unsigned PHI_W   = 8,
  parameter int unsigned DWELL_W = 16
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               start,
  input  logic               stop,
  input  logic [PHI_W-1:0]   cfg_start_inc,
  input  logic [PHI_W-1:0]   cfg_stop_inc,
  input  logic [PHI_W-1:0]   cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               cfg_repeat,
  output logic [PHI_W-1:0]   phi_inc,
  output logic               nco_clken,
  output logic               busy,
  output logic               done,
  output logic               wrap
);

  typedef enum logic [1:0] {
    IDLE,
    DWELL,
    DONE
  } state_t;

  state_t               state;
  logic [PHI_W-1:0]     start_q;
  logic [PHI_W-1:0]     stop_q;
  logic [PHI_W-1:0]     step_q;
  logic [DWELL_W-1:0]   dwell_q;
  logic                 repeat_q;
  logic                 up_q;
  logic [DWELL_W-1:0]   cnt;

  logic [PHI_W:0]       sum;
  logic [PHI_W:0]       diff;
  logic [PHI_W-1:0]     next_phi;

  // Next sweep value, computed one bit wider and clamped to the stop value.
  always_comb begin
    sum      = {1'b0, phi_inc} + {1'b0, step_q};
    diff     = {1'b0, phi_inc} - {1'b0, step_q};
    next_phi = stop_q;
    if (up_q) begin
      if (sum < {1'b0, stop_q})
        next_phi = sum[PHI_W-1:0];
    end else begin
      if (!diff[PHI_W] && (diff[PHI_W-1:0] > stop_q))
        next_phi = diff[PHI_W-1:0];
    end
  end

  // Sweep FSM with registered outputs and latched configuration.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= IDLE;
      phi_inc   <= '0;
      nco_clken <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wrap      <= 1'b0;
      cnt       <= '0;
      start_q   <= '0;
      stop_q    <= '0;
      step_q    <= '0;
      dwell_q   <= '0;
      repeat_q  <= 1'b0;
      up_q      <= 1'b0;
    end else begin
      done <= 1'b0;
      wrap <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && !stop) begin
            start_q   <= cfg_start_inc;
            stop_q    <= cfg_stop_inc;
            // A zero step would never reach the stop value; use 1 instead.
            step_q    <= (cfg_step == '0) ? {{(PHI_W-1){1'b0}}, 1'b1} : cfg_step;
            dwell_q   <= cfg_dwell;
            repeat_q  <= cfg_repeat;
            up_q      <= (cfg_start_inc <= cfg_stop_inc);
            phi_inc   <= cfg_start_inc;
            nco_clken <= 1'b1;
            busy      <= 1'b1;
            cnt       <= '0;
            state     <= DWELL;
          end
        end
        DWELL: begin
          if (stop) begin
            nco_clken <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (cnt == dwell_q) begin
            cnt <= '0;
            if (phi_inc != stop_q) begin
              phi_inc <= next_phi;
            end else if (repeat_q) begin
              phi_inc <= start_q;
              wrap    <= 1'b1;
            end else begin
              done      <= 1'b1;
              busy      <= 1'b0;
              nco_clken <= 1'b0;
              state     <= DONE;
            end
          end else begin
            cnt <= cnt + DWELL_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Directed testbench for nco_sweep_ctrl with hand-computed expectations.
module tb_nco_sweep_ctrl;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        start;
  logic        stop;
  logic [7:0]  cfg_start_inc;
  logic [7:0]  cfg_stop_inc;
  logic [7:0]  cfg_step;
  logic [15:0] cfg_dwell;
  logic        cfg_repeat;
  logic [7:0]  phi_inc;
  logic        nco_clken;
  logic        busy;
  logic        done;
  logic        wrap;

  int passes = 0;
  int total  = 0;

  nco_sweep_ctrl #(.PHI_W(8), .DWELL_W(16)) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .start         (start),
    .stop          (stop),
    .cfg_start_inc (cfg_start_inc),
    .cfg_stop_inc  (cfg_stop_inc),
    .cfg_step      (cfg_step),
    .cfg_dwell     (cfg_dwell),
    .cfg_repeat    (cfg_repeat),
    .phi_inc       (phi_inc),
    .nco_clken     (nco_clken),
    .busy          (busy),
    .done          (done),
    .wrap          (wrap)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic chk_phi(input string tag, input logic [7:0] exp);
    total++;
    assert (phi_inc === exp) passes++;
    else $error("FAIL %s.phi observed=%0d expected=%0d", tag, phi_inc, exp);
  endtask

  task automatic chk_all(input string tag, input logic [7:0] p, input logic b,
                         input logic c, input logic d, input logic w);
    chk_phi(tag, p);
    chk_bit({tag, ".busy"},  busy,      b);
    chk_bit({tag, ".clken"}, nco_clken, c);
    chk_bit({tag, ".done"},  done,      d);
    chk_bit({tag, ".wrap"},  wrap,      w);
  endtask

  task automatic set_cfg(input logic [7:0] s, input logic [7:0] e, input logic [7:0] st,
                         input logic [15:0] dw, input logic rep);
    cfg_start_inc = s;
    cfg_stop_inc  = e;
    cfg_step      = st;
    cfg_dwell     = dw;
    cfg_repeat    = rep;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    sys_rst = 1'b1;
    start   = 1'b0;
    stop    = 1'b0;
    set_cfg(8'd0, 8'd0, 8'd0, 16'd0, 1'b0);
    tick();
    tick();
    chk_all("reset", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    sys_rst = 1'b0;
    tick();
    chk_all("idle", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Nominal up sweep; cfg changed after start must be ignored.
    set_cfg(8'd10, 8'd40, 8'd10, 16'd2, 1'b0);
    pulse_start();
    set_cfg(8'd99, 8'd1, 8'd77, 16'd0, 1'b1);
    for (int v = 1; v <= 4; v++) begin
      for (int k = 0; k < 3; k++) begin
        chk_all("up", 8'(v * 10), 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
      end
    end
    chk_all("up_done", 8'd40, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk_all("up_after", 8'd40, 1'b0, 1'b0, 1'b0, 1'b0);

    // Clamp at top of range.
    set_cfg(8'd250, 8'd255, 8'd10, 16'd0, 1'b0);
    pulse_start();
    chk_all("clamp0", 8'd250, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("clamp1", 8'd255, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("clamp_done", 8'd255, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();

    // Down sweep with repeat, stopped coincident with expiry at the stop value.
    set_cfg(8'd200, 8'd190, 8'd5, 16'd0, 1'b1);
    pulse_start();
    chk_all("dn0", 8'd200, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("dn1", 8'd195, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("dn2", 8'd190, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("dn_wrap", 8'd200, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    chk_all("dn4", 8'd195, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("dn5", 8'd190, 1'b1, 1'b1, 1'b0, 1'b0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_all("dn_stop", 8'd190, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_all("dn_idle", 8'd190, 1'b0, 1'b0, 1'b0, 1'b0);

    // Abort in 2nd dwell cycle of value 20.
    set_cfg(8'd10, 8'd40, 8'd10, 16'd2, 1'b0);
    pulse_start();
    for (int k = 0; k < 4; k++) tick();
    chk_all("abort_pre", 8'd20, 1'b1, 1'b1, 1'b0, 1'b0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_all("abort", 8'd20, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 12; k++) begin
      tick();
      chk_bit("abort_nodone", done, 1'b0);
    end
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    chk_all("start_stop", 8'd20, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_bit("start_stop2.busy", busy, 1'b0);

    // Single value with zero step; start during the sweep is ignored.
    set_cfg(8'd50, 8'd50, 8'd0, 16'd3, 1'b0);
    pulse_start();
    chk_all("single0", 8'd50, 1'b1, 1'b1, 1'b0, 1'b0);
    set_cfg(8'd99, 8'd120, 8'd1, 16'd0, 1'b0);
    pulse_start();
    for (int k = 1; k < 4; k++) begin
      chk_all("single", 8'd50, 1'b1, 1'b1, 1'b0, 1'b0);
      if (k < 3) tick();
    end
    tick();
    chk_all("single_done", 8'd50, 1'b0, 1'b0, 1'b1, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_all("done_start_ign", 8'd50, 1'b0, 1'b0, 1'b0, 1'b0);

    // Zero step over a range behaves as step 1.
    set_cfg(8'd5, 8'd7, 8'd0, 16'd0, 1'b0);
    pulse_start();
    chk_phi("z0", 8'd5);
    tick();
    chk_phi("z1", 8'd6);
    tick();
    chk_phi("z2", 8'd7);
    tick();
    chk_all("z_done", 8'd7, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();

    // Reset mid-sweep, then reset priority over start, then a fresh sweep.
    set_cfg(8'd10, 8'd40, 8'd10, 16'd2, 1'b1);
    pulse_start();
    for (int k = 0; k < 4; k++) tick();
    sys_rst = 1'b1;
    tick();
    chk_all("rst_mid", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_all("rst_prio", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    sys_rst = 1'b0;
    tick();
    chk_all("rst_after", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_cfg(8'd10, 8'd40, 8'd10, 16'd2, 1'b0);
    pulse_start();
    chk_all("fresh0", 8'd10, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) tick();
    chk_all("fresh1", 8'd20, 1'b1, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
